lfsr_tick_divider: RTL and testbench
====================================

# lfsr_tick_divider

Parametrised LFSR-based tick generator: counts enabled clock cycles with a maximal-length Galois LFSR and emits a one-cycle `Tick` every `Ratio` enabled cycles. The division ratio and mode are loaded at run time through a valid/ready handshake, and the block computes its own terminal LFSR state. It serves as the game's general-purpose timebase, covering fixed-count use, free-running dividers and one-shot countdowns.

## Interface
- `WIDTH`, default 4: LFSR and ratio width. Legal values are 4..8.
- `Clock`  in  1: sole clock, rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `Enable`  in  1: count qualifier. Ignored outside RUN.
- `LoadValid`  in  1: configuration request.
- `LoadReady`  out  1: block can accept a configuration.
- `Ratio`  in  WIDTH: enabled cycles per tick. Legal range is 1..2^WIDTH-1.
- `OneShot`  in  1: sampled at load. 0 = free-running, 1 = stop after first tick.
- `Tick`  out  1: registered one-cycle pulse.
- `Running`  out  1: high while in RUN.
- `Error`  out  1: one-cycle pulse when a load carries `Ratio`=0.

## Operation
- **LFSR step** (seed is all ones):
  - next[0] = msb.
  - next[i] = cur[i-1] ^ (TAP[i] & msb) for i ≥ 1.
- **Polynomials per WIDTH** (TAP bits in brackets):
  - 4: x^4+x+1 [1]
  - 5: x^5+x^2+1 [2]
  - 6: x^6+x+1 [1]
  - 7: x^7+x+1 [1]
  - 8: x^8+x^6+x^5+x^4+1 [4,5,6]
- **States:** IDLE, SETUP, RUN, DONE. Reset enters IDLE.
- **Handshake:**
  - `LoadReady` = 1 in IDLE, RUN and DONE; 0 in SETUP.
  - A load is accepted on a rising edge where `LoadValid` & `LoadReady`.
  - `Ratio`≠0: latch `OneShot`, set down-counter = `Ratio`-1, set shadow LFSR = seed, go to SETUP. Any run in progress is aborted.
  - `Ratio`=0: `Error` pulses the next cycle. State, configuration and LFSR are unchanged.
- **SETUP:**
  - Counter ≠ 0: step shadow, decrement counter.
  - Counter = 0: terminal ← shadow, LFSR ← seed, go to RUN.
  - SETUP lasts exactly `Ratio` cycles. `Enable` is ignored.
- **RUN, edge with `Enable`=1:**
  - LFSR = terminal: LFSR ← seed, `Tick` ← 1. If OneShot, go to DONE.
  - Otherwise: step LFSR, `Tick` ← 0.
- **RUN, edge with `Enable`=0:** LFSR holds, `Tick` ← 0.
- **DONE:** LFSR holds, `Tick` = 0. Only a new load leaves DONE.
- **IDLE:** nothing counts. `Enable` is ignored.
- **Priority:** an accepted load beats terminal detection on the same edge. No `Tick` is issued; SETUP begins.
- **Ratio=1 with `Enable` held high:** `Tick` stays high every cycle. This is legal.

## Timing
- **Reset values** (asserted asynchronously, immediately):
  - `Tick`=0, `Running`=0, `Error`=0, `LoadReady`=1.
  - State=IDLE, LFSR=seed, terminal=seed, OneShot=0.
- **Load latency:**
  - Accept edge T: SETUP during T+1..T+`Ratio`.
  - RUN and `Running`=1 from T+`Ratio`+1.
- **Tick latency:**
  - `Tick` is registered; it is high in the cycle after the `Ratio`th enabled RUN edge.
  - With `Enable` continuous, ticks are exactly `Ratio` cycles apart.
- **Running:** falls in the same cycle `Tick` rises for a one-shot. Goes low the cycle after a mid-RUN load is accepted.
- **Error:** high for exactly one cycle, the cycle after the accepting edge.
- **Reset mid-SETUP or mid-RUN:** returns to IDLE. The configuration is lost and a reload is required.

## Test plan
1. **Reset and idle:** WIDTH=4, assert `Reset`=0 mid-cycle, then release.
   - Outputs go 0/0/0, `LoadReady`=1 immediately.
   - Toggling `Enable` in IDLE gives no `Tick`.
2. **Divide-by-10:** WIDTH=4, load `Ratio`=10, `OneShot`=0.
   - SETUP lasts 10 cycles; terminal = 4'b1100.
   - With `Enable` high, `Tick` pulses every 10 cycles for ≥5 periods.
   - With `Enable` at a 50 % random duty, `Tick` appears after every 10th enabled edge.
3. **Extremes:** WIDTH=4, `Ratio`=15, then `Ratio`=1.
   - `Ratio`=15: period 15, no premature tick.
   - `Ratio`=1: `Tick` stays high while `Enable` is high.
   - Repeat at WIDTH=8 with `Ratio`=255 (period 255) and `Ratio`=200.
4. **One-shot:** load `Ratio`=5, `OneShot`=1.
   - A single `Tick` after 5 enables; `Running` drops with it.
   - No further ticks over 50 enabled cycles.
   - A reload restarts the countdown.
5. **Error and collision:**
   - In RUN, load `Ratio`=0: one-cycle `Error`, and ticks continue on the original schedule.
   - Load `Ratio`=7 on the terminal edge: no `Tick`, SETUP runs 7 cycles, then a period of 7.
6. **Reset mid-operation:** assert `Reset` during SETUP, then separately during RUN.
   - Each time: IDLE, `Running`=0, no `Tick` until a reload.

Source files
------------

// File: rtl/lfsr_tick_divider.sv
// Run-time programmable tick divider: a Galois LFSR counts enabled cycles and fires Tick
// when it reaches a terminal state that the block derives itself during a Ratio-cycle SETUP.
module lfsr_tick_divider #(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             LoadValid,
   output logic             LoadReady,
   input  logic [WIDTH-1:0] Ratio,
   input  logic             OneShot,
   output logic             Tick,
   output logic             Running,
   output logic             Error
);

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

   function automatic logic [7:0] tap_mask(input int w);
      case (w)
         5:       return 8'h04;
         8:       return 8'h70;
         default: return 8'h02;
      endcase
   endfunction

   localparam logic [7:0]       TAP8 = tap_mask(WIDTH);
   localparam logic [WIDTH-1:0] TAP  = TAP8[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED = '1;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
      logic msb;
      msb = cur[WIDTH-1];
      return {cur[WIDTH-2:0], msb} ^ (TAP & {WIDTH{msb}});
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] terminal_q, terminal_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             one_shot_q, one_shot_d;
   logic             tick_q, tick_d;
   logic             error_q, error_d;
   logic             load_ok;

   assign LoadReady = (state_q != SETUP);
   assign Running   = (state_q == RUN);
   assign Tick      = tick_q;
   assign Error     = error_q;
   assign load_ok   = LoadValid && LoadReady;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         lfsr_q     <= SEED;
         shadow_q   <= SEED;
         terminal_q <= SEED;
         count_q    <= '0;
         one_shot_q <= 1'b0;
         tick_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         shadow_q   <= shadow_d;
         terminal_q <= terminal_d;
         count_q    <= count_d;
         one_shot_q <= one_shot_d;
         tick_q     <= tick_d;
         error_q    <= error_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      shadow_d   = shadow_q;
      terminal_d = terminal_q;
      count_d    = count_q;
      one_shot_d = one_shot_q;
      tick_d     = 1'b0;
      error_d    = 1'b0;

      // A valid load wins over everything, including a terminal hit on the same edge.
      if (load_ok && (Ratio != '0)) begin
         one_shot_d = OneShot;
         count_d    = Ratio - ONE;
         shadow_d   = SEED;
         state_d    = SETUP;
      end else begin
         error_d = load_ok;
         case (state_q)
            SETUP: begin
               // Walk the shadow Ratio-1 steps; that state is the one RUN must match.
               if (count_q != '0) begin
                  shadow_d = lfsr_step(shadow_q);
                  count_d  = count_q - ONE;
               end else begin
                  terminal_d = shadow_q;
                  lfsr_d     = SEED;
                  state_d    = RUN;
               end
            end
            RUN: begin
               if (Enable) begin
                  if (lfsr_q == terminal_q) begin
                     lfsr_d = SEED;
                     tick_d = 1'b1;
                     if (one_shot_q) state_d = DONE;
                  end else begin
                     lfsr_d = lfsr_step(lfsr_q);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_tick_divider.sv
// Bench for lfsr_tick_divider at WIDTH=4 and WIDTH=8 against an enabled-edge counting model.
module tb_lfsr_tick_divider;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       en = 1'b0, lv = 1'b0, os = 1'b0, sel = 1'b0;
   logic [7:0] rv = 8'd0;
   logic       rdy4, tick4, run4, err4;
   logic       rdy8, tick8, run8, err8;
   logic [3:0] obs;

   int passed = 0;
   int total  = 0;

   // reference model: counts cycles and enabled edges, knows nothing about LFSR states
   int m_ratio = 0, m_setup_left = 0, m_cnt = 0;
   bit m_run = 0, m_os = 0, exp_tick = 0, exp_err = 0;

   always #5 Clock = ~Clock;

   lfsr_tick_divider #(.WIDTH(4)) dut4 (
      .Clock(Clock), .Reset(Reset), .Enable(en), .LoadValid(lv & ~sel), .LoadReady(rdy4),
      .Ratio(rv[3:0]), .OneShot(os), .Tick(tick4), .Running(run4), .Error(err4));

   lfsr_tick_divider #(.WIDTH(8)) dut8 (
      .Clock(Clock), .Reset(Reset), .Enable(en), .LoadValid(lv & sel), .LoadReady(rdy8),
      .Ratio(rv), .OneShot(os), .Tick(tick8), .Running(run8), .Error(err8));

   assign obs = sel ? {tick8, run8, rdy8, err8} : {tick4, run4, rdy4, err4};

   function automatic logic [3:0] exp_vec();
      return {exp_tick, m_run, (m_setup_left == 0), exp_err};
   endfunction

   task automatic cyc(input logic e, input logic l, input logic [7:0] r, input logic o);
      bit ready;
      en = e; lv = l; rv = r; os = o;
      @(posedge Clock);
      ready = (m_setup_left == 0);
      exp_tick = 0;
      exp_err  = 0;
      if (l && ready && r != 0) begin
         m_ratio = r; m_os = o; m_setup_left = r; m_run = 0; m_cnt = 0;
      end else begin
         if (l && ready) exp_err = 1;
         if (m_setup_left > 0) begin
            m_setup_left--;
            if (m_setup_left == 0) begin m_run = 1; m_cnt = 0; end
         end else if (m_run && e) begin
            m_cnt++;
            if (m_cnt == m_ratio) begin
               exp_tick = 1; m_cnt = 0;
               if (m_os) m_run = 0;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      #2 Reset = 1'b0;
      #1;
      m_run = 0; m_setup_left = 0; m_cnt = 0; exp_tick = 0; exp_err = 0;
   endtask

   task automatic release_reset();
      #2 Reset = 1'b1;
   endtask

   task automatic test_reset();
      sel = 0;
      do_reset();
      total++;
      if (obs !== 4'b0010) $display("FAIL reset_async obs=%b want=0010", obs); else passed++;
      release_reset();
      for (int i = 0; i < 20; i++) begin
         cyc($urandom_range(0, 1), 0, 0, 0);
         total++;
         if (obs !== exp_vec()) $display("FAIL idle_enable cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
   endtask

   task automatic test_div10();
      int ticks = 0;
      sel = 0;
      cyc(0, 1, 10, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 0);
         total++;
         if (obs !== exp_vec()) $display("FAIL div10_setup cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
      total++;
      if (dut4.terminal_q !== 4'b1100) $display("FAIL div10_terminal got=%b want=1100", dut4.terminal_q);
      else passed++;
      for (int i = 0; i < 55; i++) begin
         cyc(1, 0, 0, 0);
         if (obs[3]) ticks++;
         total++;
         if (obs !== exp_vec()) $display("FAIL div10_cont cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
      total++;
      if (ticks !== 5) $display("FAIL div10_tick_count got=%0d want=5", ticks); else passed++;
      for (int i = 0; i < 120; i++) begin
         cyc($urandom_range(0, 1), 0, 0, 0);
         total++;
         if (obs !== exp_vec()) $display("FAIL div10_duty cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
   endtask

   task automatic test_extremes();
      sel = 0;
      cyc(0, 1, 15, 0);
      for (int i = 0; i < 15 + 50; i++) begin
         cyc(1, 0, 0, 0);
         total++;
         if (obs !== exp_vec()) $display("FAIL ratio15 cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
      cyc(1, 1, 1, 0);
      for (int i = 0; i < 30; i++) begin
         cyc((i < 20) ? 1'b1 : 1'(($urandom_range(0, 1))), 0, 0, 0);
         total++;
         if (obs !== exp_vec()) $display("FAIL ratio1 cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
      do_reset();
      release_reset();
      sel = 1;
      cyc(1, 1, 255, 0);
      for (int i = 0; i < 255 + 520; i++) begin
         cyc(1, 0, 0, 0);
         total++;
         if (obs !== exp_vec()) $display("FAIL ratio255 cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
      cyc(1, 1, 200, 0);
      for (int i = 0; i < 200 + 420; i++) begin
         cyc((i % 7 == 3) ? 1'b0 : 1'b1, 0, 0, 0);
         total++;
         if (obs !== exp_vec()) $display("FAIL ratio200 cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
      do_reset();
      release_reset();
      sel = 0;
   endtask

   task automatic test_oneshot();
      int ticks = 0;
      sel = 0;
      for (int pass = 0; pass < 2; pass++) begin
         ticks = 0;
         cyc(1, 1, 5, 1);
         for (int i = 0; i < 5 + 55; i++) begin
            cyc(1, 0, 0, 0);
            if (obs[3]) ticks++;
            total++;
            if (obs !== exp_vec()) $display("FAIL oneshot p%0d cyc %0d obs=%b want=%b", pass, i, obs, exp_vec());
            else passed++;
         end
         total++;
         if (ticks !== 1) $display("FAIL oneshot_count p%0d got=%0d want=1", pass, ticks); else passed++;
      end
   endtask

   task automatic test_error_collision();
      bit hit = 0;
      sel = 0;
      cyc(1, 1, 6, 0);
      for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      total++;
      if (obs !== exp_vec() || obs[0] !== 1'b1) $display("FAIL error_pulse obs=%b want=%b", obs, exp_vec());
      else passed++;
      for (int i = 0; i < 30; i++) begin
         cyc($urandom_range(0, 1), 0, 0, 0);
         total++;
         if (obs !== exp_vec()) $display("FAIL error_after cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
      cyc(1, 1, 4, 0);
      for (int i = 0; i < 40 && !hit; i++) begin
         if (m_run && m_cnt == m_ratio - 1) begin
            cyc(1, 1, 7, 0);
            hit = 1;
         end else begin
            cyc(1, 0, 0, 0);
         end
      end
      total++;
      if (!hit || obs !== 4'b0000) $display("FAIL collision_edge hit=%0d obs=%b want=0000", hit, obs);
      else passed++;
      for (int i = 0; i < 7 + 30; i++) begin
         cyc(1, 0, 0, 0);
         total++;
         if (obs !== exp_vec()) $display("FAIL collision_after cyc %0d obs=%b want=%b", i, obs, exp_vec());
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      sel = 0;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            cyc(1, 1, 9, 0);
            for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
         end else begin
            cyc(1, 1, 3, 0);
            for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
         end
         do_reset();
         total++;
         if (obs !== 4'b0010) $display("FAIL reset_mid p%0d obs=%b want=0010", pass, obs); else passed++;
         release_reset();
         for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0);
            total++;
            if (obs !== exp_vec()) $display("FAIL reset_mid_idle p%0d cyc %0d obs=%b want=%b", pass, i, obs, exp_vec());
            else passed++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      #3;
      test_reset();
      test_div10();
      test_extremes();
      test_oneshot();
      test_error_collision();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
